// File: rtl/dqn_pkg.sv
// Shared DQN definitions: fixed-point widths, layer sizes, FSM states and the
// saturating fixed-point rescale used by every MAC path.
package dqn_pkg;

    localparam int DW        = 16;
    localparam int FRAC_BITS = 8;
    localparam int N_IN      = 9;
    localparam int N_ACT     = 5;
    localparam int ACC_W     = 2 * DW + $clog2(N_IN);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SAT
    } state_t;

    // Floor-shift back to DW fractional format, clamping to the signed DW range.
    function automatic logic signed [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic        [ACC_W-DW:0] upper;
        shifted = acc >>> FRAC_BITS;
        upper   = shifted[ACC_W-1:DW-1];
        if (upper == '0 || upper == '1) begin
            sat_shift = shifted[DW-1:0];
        end else if (shifted[ACC_W-1]) begin
            sat_shift = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat_shift = {1'b0, {(DW-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/layer2_mac_lane.sv
// One output lane of the layer-2 forward pass: signed multiply-accumulate with a
// combinational saturated/rescaled view of the accumulator.
module layer2_mac_lane
    import dqn_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic signed [DW-1:0] h,
    input  logic signed [DW-1:0] w,
    output logic signed [DW-1:0] q
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [2*DW-1:0]  prod;

    always_comb begin
        prod  = h * w;
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign q = sat_shift(acc_q);

endmodule

// File: rtl/layer2_fwd_mac.sv
// Layer-2 DQN forward pass: Q_k = sum_i h_i * w2_k[i] over N_IN rows, five lanes.
// Optional LAYER2_ARGMAX_EN adds registered best_act/best_q outputs.
module layer2_fwd_mac
    import dqn_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_IN*DW-1:0] h_flat,
    input  logic [DW-1:0]      w2_1,
    input  logic [DW-1:0]      w2_2,
    input  logic [DW-1:0]      w2_3,
    input  logic [DW-1:0]      w2_4,
    input  logic [DW-1:0]      w2_5,
    output logic [3:0]         st,
    output logic               busy,
    output logic [DW-1:0]      q_1,
    output logic [DW-1:0]      q_2,
    output logic [DW-1:0]      q_3,
    output logic [DW-1:0]      q_4,
    output logic [DW-1:0]      q_5,
    output logic               q_valid
`ifdef LAYER2_ARGMAX_EN
   ,output logic [2:0]         best_act,
    output logic [DW-1:0]      best_q
`endif
);

    state_t               state_q, state_d;
    logic [3:0]           st_q, st_d;
    logic                 busy_q, busy_d;
    logic                 q_valid_q, q_valid_d;
    logic signed [DW-1:0] q_q [N_ACT];
    logic signed [DW-1:0] q_d [N_ACT];
    logic signed [DW-1:0] h_q [N_IN];
    logic signed [DW-1:0] h_d [N_IN];

    logic                 lane_clr;
    logic                 lane_en;
    logic signed [DW-1:0] h_cur;
    logic signed [DW-1:0] w_vec  [N_ACT];
    logic signed [DW-1:0] lane_q [N_ACT];

    assign w_vec[0] = w2_1;
    assign w_vec[1] = w2_2;
    assign w_vec[2] = w2_3;
    assign w_vec[3] = w2_4;
    assign w_vec[4] = w2_5;
    assign h_cur    = h_q[st_q];

    for (genvar k = 0; k < N_ACT; k++) begin : g_lane
        layer2_mac_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (lane_clr),
            .en    (lane_en),
            .h     (h_cur),
            .w     (w_vec[k]),
            .q     (lane_q[k])
        );
    end

    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        busy_d    = busy_q;
        q_valid_d = 1'b0;
        q_d       = q_q;
        h_d       = h_q;
        lane_clr  = 1'b0;
        lane_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_IN; i++) begin
                        h_d[i] = h_flat[i*DW +: DW];
                    end
                    lane_clr = 1'b1;
                    st_d     = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                lane_en = 1'b1;
                if (st_q == 4'(N_IN - 1)) begin
                    st_d    = '0;
                    state_d = SAT;
                end else begin
                    st_d = st_q + 4'd1;
                end
            end
            SAT: begin
                q_d       = lane_q;
                q_valid_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                st_d    = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            st_q      <= '0;
            busy_q    <= 1'b0;
            q_valid_q <= 1'b0;
            for (int k = 0; k < N_ACT; k++) begin
                q_q[k] <= '0;
            end
            for (int i = 0; i < N_IN; i++) begin
                h_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            busy_q    <= busy_d;
            q_valid_q <= q_valid_d;
            q_q       <= q_d;
            h_q       <= h_d;
        end
    end

    assign st      = st_q;
    assign busy    = busy_q;
    assign q_valid = q_valid_q;
    assign q_1     = q_q[0];
    assign q_2     = q_q[1];
    assign q_3     = q_q[2];
    assign q_4     = q_q[3];
    assign q_5     = q_q[4];

`ifdef LAYER2_ARGMAX_EN
    logic [2:0]           best_act_q, best_act_d;
    logic signed [DW-1:0] best_q_q, best_q_d;
    logic [2:0]           arg_idx;
    logic signed [DW-1:0] arg_val;

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        arg_idx = '0;
        arg_val = lane_q[0];
        for (int k = 1; k < N_ACT; k++) begin
            if (lane_q[k] > arg_val) begin
                arg_idx = 3'(k);
                arg_val = lane_q[k];
            end
        end
        best_act_d = best_act_q;
        best_q_d   = best_q_q;
        if (state_q == SAT) begin
            best_act_d = arg_idx;
            best_q_d   = arg_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_act_q <= '0;
            best_q_q   <= '0;
        end else begin
            best_act_q <= best_act_d;
            best_q_q   <= best_q_d;
        end
    end

    assign best_act = best_act_q;
    assign best_q   = best_q_q;
`endif

endmodule

// File: tb/tb_layer2_fwd_mac.sv
// Directed self-checking bench for layer2_fwd_mac with a behavioural weight store
// driven from st; argmax checks are compiled only with LAYER2_ARGMAX_EN.
module tb_layer2_fwd_mac;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [143:0] h_flat;
    logic [15:0]  w2_1, w2_2, w2_3, w2_4, w2_5;
    logic [3:0]   st;
    logic         busy;
    logic [15:0]  q_1, q_2, q_3, q_4, q_5;
    logic         q_valid;
`ifdef LAYER2_ARGMAX_EN
    logic [2:0]   best_act;
    logic [15:0]  best_q;
`endif

    int           nCompared;
    int           nMismatched;
    int           wMode;
    logic [15:0]  wConst [5];

    layer2_fwd_mac dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .h_flat   (h_flat),
        .w2_1     (w2_1),
        .w2_2     (w2_2),
        .w2_3     (w2_3),
        .w2_4     (w2_4),
        .w2_5     (w2_5),
        .st       (st),
        .busy     (busy),
        .q_1      (q_1),
        .q_2      (q_2),
        .q_3      (q_3),
        .q_4      (q_4),
        .q_5      (q_5),
        .q_valid  (q_valid)
`ifdef LAYER2_ARGMAX_EN
       ,.best_act (best_act),
        .best_q   (best_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight store model: constant per lane, or a row-dependent pattern keyed on st.
    always_comb begin
        w2_1 = wConst[0];
        w2_2 = wConst[1];
        w2_3 = wConst[2];
        w2_4 = wConst[3];
        w2_5 = wConst[4];
        if (wMode == 1) begin
            w2_1 = (st == 4'd0) ? 16'h0100 : 16'h0000;
            w2_2 = (st == 4'd8) ? 16'h0100 : 16'h0000;
            w2_3 = 16'h0080;
            w2_4 = 16'hFF00;
            w2_5 = (st[0] == 1'b0) ? 16'h0100 : 16'h0000;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic setWeights(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [15:0] d, input logic [15:0] e);
        wMode     = 0;
        wConst[0] = a;
        wConst[1] = b;
        wConst[2] = c;
        wConst[3] = d;
        wConst[4] = e;
    endtask

    // Pulses start, optionally re-pulses it at sample restartAt, and returns at the q_valid cycle.
    task automatic applyStimulus(input logic [143:0] hv, input int restartAt, input logic [143:0] altH,
                                 output int lat, output int busyCnt, output int stErr);
        lat     = -1;
        busyCnt = 0;
        stErr   = 0;
        h_flat  = hv;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (q_valid) begin
                lat = n;
                break;
            end
            if (busy) busyCnt++;
            if (int'(st) != ((n <= 8) ? n : 0)) stErr++;
            if (n == restartAt) begin
                h_flat = altH;
                start  = 1'b1;
            end
        end
    endtask

    task automatic countPulses(input int cycles, output int pulses);
        pulses = 0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (q_valid) pulses++;
        end
    endtask

    int lat, busyCnt, stErr, pulses;
    logic [143:0] hIdx;

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        start       = 1'b0;
        h_flat      = '0;
        setWeights(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 9; i++) hIdx[i*16 +: 16] = 16'((i + 1) * 256);

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_st", 32'(st), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_qvalid", 32'(q_valid), 32'h0);
        checkOutput("reset_q1", 32'(q_1), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] unity inputs and weights");
        setWeights(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        applyStimulus({9{16'h0100}}, -1, '0, lat, busyCnt, stErr);
        checkOutput("unity_latency", 32'(lat), 32'd10);
        checkOutput("unity_busy_cycles", 32'(busyCnt), 32'd10);
        checkOutput("unity_st_sequence", 32'(stErr), 32'd0);
        checkOutput("unity_q1", 32'(q_1), 32'h0900);
        checkOutput("unity_q5", 32'(q_5), 32'h0900);
        checkOutput("unity_busy_at_valid", 32'(busy), 32'h0);
        countPulses(1, pulses);
        checkOutput("unity_valid_single", 32'(pulses), 32'd0);
        checkOutput("unity_q_held", 32'(q_3), 32'h0900);

        $display("[TB] saturation");
        setWeights(16'h7F00, 16'h8100, 16'h7F00, 16'h8100, 16'h7F00);
        applyStimulus({9{16'h7F00}}, -1, '0, lat, busyCnt, stErr);
        checkOutput("sat_pos_q1", 32'(q_1), 32'h7FFF);
        checkOutput("sat_neg_q2", 32'(q_2), 32'h8000);
        checkOutput("sat_neg_q4", 32'(q_4), 32'h8000);

        $display("[TB] floor truncation");
        setWeights(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
        applyStimulus({9{16'hFFFF}}, -1, '0, lat, busyCnt, stErr);
        checkOutput("trunc_q1", 32'(q_1), 32'hFFFF);
        checkOutput("trunc_q5", 32'(q_5), 32'hFFFF);

        $display("[TB] row-indexed weights");
        wMode = 1;
        applyStimulus(hIdx, -1, '0, lat, busyCnt, stErr);
        checkOutput("index_q1", 32'(q_1), 32'h0100);
        checkOutput("index_q2", 32'(q_2), 32'h0900);
        checkOutput("index_q3", 32'(q_3), 32'h1680);
        checkOutput("index_q4", 32'(q_4), 32'hD300);
        checkOutput("index_q5", 32'(q_5), 32'h1900);

        $display("[TB] start while busy is ignored");
        setWeights(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        applyStimulus({9{16'h0100}}, 3, {9{16'h0200}}, lat, busyCnt, stErr);
        checkOutput("restart_latency", 32'(lat), 32'd10);
        checkOutput("restart_q1", 32'(q_1), 32'h0900);
        countPulses(14, pulses);
        checkOutput("restart_extra_pulses", 32'(pulses), 32'd0);

        $display("[TB] back-to-back start in q_valid cycle");
        applyStimulus({9{16'h0100}}, -1, '0, lat, busyCnt, stErr);
        applyStimulus({9{16'h0200}}, -1, '0, lat, busyCnt, stErr);
        checkOutput("b2b_latency", 32'(lat), 32'd10);
        checkOutput("b2b_q2", 32'(q_2), 32'h1200);

        $display("[TB] reset mid-run");
        h_flat = {9{16'h0100}};
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_q2", 32'(q_2), 32'h0);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_st", 32'(st), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        countPulses(12, pulses);
        checkOutput("midrst_no_valid", 32'(pulses), 32'd0);
        applyStimulus({9{16'h0100}}, -1, '0, lat, busyCnt, stErr);
        checkOutput("midrst_recover_lat", 32'(lat), 32'd10);
        checkOutput("midrst_recover_q1", 32'(q_1), 32'h0900);

        $display("[TB] per-lane values with tie");
        setWeights(16'h0300, 16'h0700, 16'h0700, 16'hFE00, 16'h0000);
        applyStimulus({{8{16'h0000}}, 16'h0100}, -1, '0, lat, busyCnt, stErr);
        checkOutput("argq_q1", 32'(q_1), 32'h0300);
        checkOutput("argq_q3", 32'(q_3), 32'h0700);
        checkOutput("argq_q4", 32'(q_4), 32'hFE00);
`ifdef LAYER2_ARGMAX_EN
        checkOutput("argmax_act", 32'(best_act), 32'd1);
        checkOutput("argmax_q", 32'(best_q), 32'h0700);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
